vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: the successor to our fixed 640x480 sync block. It produces horizontal and vertical sync, display-enable, pixel coordinates, line/frame start strobes and a frame counter. All sync and porch widths, sync polarities and counter widths are configurable, and a clock-enable input allows running from a faster system clock. It sits at the front of the video pipeline and feeds the Game-of-Life renderer and the colour output stage.

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Free-running pixel/line counters advance on clk_en; a single output
// register stage turns the current counter state into sync, display-enable,
// coordinates, start strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int CW        = 10,
  parameter int FW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Region boundaries expressed at counter width so every compare is same-width.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END     = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic          HS_ON      = (H_POL != 0);
  localparam logic          VS_ON      = (V_POL != 0);

  logic [CW-1:0] hc_reg, hc_next;
  logic [CW-1:0] vc_reg, vc_next;
  // Set once the first frame after reset has been presented, so that only
  // later frame starts count as completed frames.
  logic          started_reg;

  logic          de_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          line_next;
  logic          frame_next;

  // Counter advance: pixel wraps at end of line, line wraps at end of frame.
  always_comb begin
    hc_next = hc_reg + CW'(1);
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = '0;
      if (vc_reg == V_LAST) begin
        vc_next = '0;
      end else begin
        vc_next = vc_reg + CW'(1);
      end
    end
  end

  // Output decode of the current counter state, registered below.
  always_comb begin
    de_next    = (hc_reg < H_VIS_END) && (vc_reg < V_VIS_END);
    hsync_next = ((hc_reg >= HS_START) && (hc_reg < HS_END)) ? HS_ON : ~HS_ON;
    vsync_next = ((vc_reg >= VS_START) && (vc_reg < VS_END)) ? VS_ON : ~VS_ON;
    line_next  = (hc_reg == '0);
    frame_next = (hc_reg == '0) && (vc_reg == '0);
  end

  // Counters, output register stage and frame counter; strobes drop on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_reg      <= '0;
      vc_reg      <= '0;
      started_reg <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (clk_en) begin
      hc_reg      <= hc_next;
      vc_reg      <= vc_next;
      hpos        <= hc_reg;
      vpos        <= vc_reg;
      de          <= de_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      line_start  <= line_next;
      frame_start <= frame_next;
      if (frame_next) begin
        started_reg <= 1'b1;
        if (started_reg) begin
          frame_count <= frame_count + FW'(1);
        end
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives a default-sized and a miniature raster generator
// with the same clk_en/reset stimulus and compares every output, every clock,
// against a pixel-index arithmetic reference model.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic clk_en;

  // Default-parameter instance
  logic       d_hsync, d_vsync, d_de, d_ls, d_fs;
  logic [9:0] d_hpos, d_vpos;
  logic [7:0] d_fc;

  // Miniature instance: 8/2/2/2, 4/1/1/1, active-high syncs, FW = 2
  logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [3:0] s_hpos, s_vpos;
  logic [1:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .hpos(d_hpos), .vpos(d_vpos),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .CW(4), .FW(2)
  ) u_small (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .hpos(s_hpos), .vpos(s_vpos),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model state: enabled edges since reset, and whether the last edge advanced.
  int n      = 0;
  bit was_en = 0;
  int cyc    = 0;

  // Period trackers
  bit d_ls_seen = 0;
  int d_ls_last = 0;
  int d_line_period = 0;
  bit s_fs_seen = 0;
  int s_fs_last = 0;
  int s_frame_period = 0;

  typedef struct {
    logic hs, vs, de, ls, fs;
    int   hp, vp, fc;
  } exp_t;

  // Expected outputs after n enabled edges: pixel n-1 of an endless raster.
  function automatic exp_t expect_of(int nn, bit en, int hv, int hf, int hsw, int hb,
                                     int vv, int vf, int vsw, int vb,
                                     bit hpol, bit vpol, int fw);
    exp_t e;
    int ht, vt, p, line, frame;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (nn == 0) begin
      e.hp = 0; e.vp = 0; e.fc = 0;
      e.de = 0; e.ls = 0; e.fs = 0;
      e.hs = ~hpol; e.vs = ~vpol;
    end else begin
      p     = nn - 1;
      e.hp  = p % ht;
      line  = p / ht;
      e.vp  = line % vt;
      frame = line / vt;
      e.fc  = frame % (1 << fw);
      e.de  = (e.hp < hv) && (e.vp < vv);
      e.hs  = (e.hp >= hv + hf && e.hp < hv + hf + hsw) ? hpol : ~hpol;
      e.vs  = (e.vp >= vv + vf && e.vp < vv + vf + vsw) ? vpol : ~vpol;
      e.ls  = en && (e.hp == 0);
      e.fs  = en && (e.hp == 0) && (e.vp == 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    exp_t ed, es;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      n = 0; was_en = 0;
    end else if (clk_en) begin
      n++; was_en = 1;
    end else begin
      was_en = 0;
    end
    ed = expect_of(n, was_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
    es = expect_of(n, was_en, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("def_hpos",  d_hpos,  ed.hp);
    chk("def_vpos",  d_vpos,  ed.vp);
    chk("def_de",    d_de,    ed.de);
    chk("def_hsync", d_hsync, ed.hs);
    chk("def_vsync", d_vsync, ed.vs);
    chk("def_ls",    d_ls,    ed.ls);
    chk("def_fs",    d_fs,    ed.fs);
    chk("def_fc",    d_fc,    ed.fc);
    chk("sm_hpos",   s_hpos,  es.hp);
    chk("sm_vpos",   s_vpos,  es.vp);
    chk("sm_de",     s_de,    es.de);
    chk("sm_hsync",  s_hsync, es.hs);
    chk("sm_vsync",  s_vsync, es.vs);
    chk("sm_ls",     s_ls,    es.ls);
    chk("sm_fs",     s_fs,    es.fs);
    chk("sm_fc",     s_fc,    es.fc);
    if (d_ls === 1'b1) begin
      if (d_ls_seen) d_line_period = cyc - d_ls_last;
      d_ls_seen = 1;
      d_ls_last = cyc;
    end
    if (s_fs === 1'b1) begin
      if (s_fs_seen) s_frame_period = cyc - s_fs_last;
      s_fs_seen = 1;
      s_fs_last = cyc;
    end
  endtask

  task automatic clear_periods();
    d_ls_seen = 0; d_line_period = 0;
    s_fs_seen = 0; s_frame_period = 0;
  endtask

  initial begin
    bit hit;
    reset  = 1'b1;
    clk_en = 1'b1;

    // Reset held for 3 clk
    for (int i = 0; i < 3; i++) step();
    $display("reset held 3 clk: hsync=%0b vsync=%0b de=%0b", d_hsync, d_vsync, d_de);

    // Free-running: two full default lines, many miniature frames
    reset = 1'b0;
    clear_periods();
    for (int i = 0; i < 1600; i++) step();
    chk("def_line_period_full", d_line_period, 800);
    chk("sm_frame_period_full", s_frame_period, 98);
    $display("free run: line period %0d, mini frame period %0d", d_line_period, s_frame_period);

    // clk_en one cycle in four
    clear_periods();
    for (int i = 0; i < 6600; i++) begin
      clk_en = (i % 4 == 0);
      step();
    end
    chk("def_line_period_div4", d_line_period, 3200);
    chk("sm_frame_period_div4", s_frame_period, 392);
    $display("clk_en/4: line period %0d, mini frame period %0d", d_line_period, s_frame_period);

    // Reset mid-frame for one clock, then restart
    clk_en = 1'b1;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      hit = (s_hpos == 4'd5) && (s_vpos == 4'd3);
    end
    chk("wait_mid_frame", hit, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) step();
    $display("mid-frame reset: restarted, mini frame_count=%0d", s_fc);

    // Randomized clk_en with occasional single-cycle resets
    for (int i = 0; i < 5000; i++) begin
      clk_en = $urandom_range(0, 1);
      reset  = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    $display("random phase done at cyc %0d", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
